// File: rtl/gcd_ctrl_if.sv
// Control/status bundle between the GCD sequencer and its host plus datapath.
// master drives request and comparator flags; slave is the sequencer.
interface gcd_ctrl_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 lt;
  logic                 gt;
  logic                 eq;
  logic                 a_zero;
  logic                 b_zero;
  logic                 ldA;
  logic                 ldB;
  logic                 sel_in;
  logic                 sel1;
  logic                 sel2;
  logic                 busy;
  logic                 done;
  logic                 err;
  logic [CNT_WIDTH-1:0] iter_cnt;

  modport master (
    output start, lt, gt, eq, a_zero, b_zero,
    input  ldA, ldB, sel_in, sel1, sel2, busy, done, err, iter_cnt
  );

  modport slave (
    input  start, lt, gt, eq, a_zero, b_zero,
    output ldA, ldB, sel_in, sel1, sel2, busy, done, err, iter_cnt
  );
endinterface

// File: rtl/gcd_ctrl_fsm.sv
// Moore sequencer for a subtractive GCD datapath with four-phase start/done handshake.
// Optional iteration limit enabled by defining GCD_ITER_LIMIT_EN.
module gcd_ctrl_fsm #(
  parameter int CNT_WIDTH = 16,
  parameter int MAX_ITER  = 255
) (
  input  logic       clk,
  input  logic       rst,
  gcd_ctrl_if.slave  bus
);

`ifdef GCD_ITER_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  localparam logic [CNT_WIDTH-1:0] ITER_LIMIT = CNT_WIDTH'(MAX_ITER);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_A  = 3'd1,
    LOAD_B  = 3'd2,
    COMPARE = 3'd3,
    SUB_A   = 3'd4,
    SUB_B   = 3'd5,
    DONE    = 3'd6,
    ERROR   = 3'd7
  } state_t;

  state_t               state_reg;
  state_t               state_next;
  logic [CNT_WIDTH-1:0] iter_reg;
  logic [CNT_WIDTH-1:0] iter_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      iter_reg  <= '0;
    end else begin
      state_reg <= state_next;
      iter_reg  <= iter_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = LOAD_A;
      LOAD_A:  state_next = LOAD_B;
      LOAD_B:  state_next = COMPARE;
      COMPARE: begin
        // Zero operands never converge, so they outrank everything else.
        if (bus.a_zero || bus.b_zero)                state_next = ERROR;
        else if (bus.eq)                             state_next = DONE;
        else if (LIMIT_EN && iter_reg == ITER_LIMIT) state_next = ERROR;
        else if (bus.lt)                             state_next = SUB_B;
        else                                         state_next = SUB_A;
      end
      SUB_A:   state_next = COMPARE;
      SUB_B:   state_next = COMPARE;
      DONE:    if (!bus.start) state_next = IDLE;
      ERROR:   if (!bus.start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Counter saturates and otherwise holds its last value for the host to read.
  always_comb begin
    iter_next = iter_reg;
    case (state_reg)
      LOAD_A:       iter_next = '0;
      SUB_A, SUB_B: if (iter_reg != '1) iter_next = iter_reg + 1'b1;
      default:      iter_next = iter_reg;
    endcase
  end

  always_comb begin
    bus.ldA    = 1'b0;
    bus.ldB    = 1'b0;
    bus.sel_in = 1'b0;
    bus.sel1   = 1'b0;
    bus.sel2   = 1'b0;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    bus.err    = 1'b0;
    case (state_reg)
      LOAD_A: begin
        bus.sel_in = 1'b1;
        bus.ldA    = 1'b1;
        bus.busy   = 1'b1;
      end
      LOAD_B: begin
        bus.sel_in = 1'b1;
        bus.ldB    = 1'b1;
        bus.busy   = 1'b1;
      end
      COMPARE: bus.busy = 1'b1;
      SUB_A: begin
        bus.sel2 = 1'b1;
        bus.ldA  = 1'b1;
        bus.busy = 1'b1;
      end
      SUB_B: begin
        bus.sel1 = 1'b1;
        bus.ldB  = 1'b1;
        bus.busy = 1'b1;
      end
      DONE:    bus.done = 1'b1;
      ERROR:   bus.err  = 1'b1;
      default: ;
    endcase
  end

  assign bus.iter_cnt = iter_reg;

endmodule

// File: tb/tb_gcd_ctrl_fsm.sv
// Directed bench for gcd_ctrl_fsm with a behavioural GCD datapath around it.
module tb_gcd_ctrl_fsm;

`ifdef GCD_ITER_LIMIT_EN
  localparam int LIM = 3;
`else
  localparam int LIM = 1000000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  gcd_ctrl_if #(.CNT_WIDTH(16)) bus ();

  gcd_ctrl_fsm #(
    .CNT_WIDTH(16),
    .MAX_ITER (3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Behavioural datapath: operand registers, muxes, subtractor, flags.
  logic [15:0] op_a = '0;
  logic [15:0] op_b = '0;
  logic [15:0] a_reg = '0;
  logic [15:0] b_reg = '0;
  logic [15:0] diff;

  assign diff       = (bus.sel1 ? b_reg : a_reg) - (bus.sel2 ? b_reg : a_reg);
  assign bus.lt     = a_reg < b_reg;
  assign bus.gt     = a_reg > b_reg;
  assign bus.eq     = a_reg == b_reg;
  assign bus.a_zero = a_reg == 16'd0;
  assign bus.b_zero = b_reg == 16'd0;

  always @(posedge clk) begin
    if (bus.ldA) a_reg <= bus.sel_in ? op_a : diff;
    if (bus.ldB) b_reg <= bus.sel_in ? op_b : diff;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] outs();
    return {bus.ldA, bus.ldB, bus.sel_in, bus.sel1, bus.sel2, bus.busy, bus.done, bus.err};
  endfunction

  // Launch a run; returns edges from start sample until done/err shows, and load cycles seen.
  task automatic run_gcd(input logic [15:0] a, input logic [15:0] b, input bit hold,
                         output int edges, output int loads);
    @(negedge clk);
    op_a = a;
    op_b = b;
    bus.start = 1'b1;
    edges = 0;
    loads = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.ldA || bus.ldB) loads++;
      if (!hold) bus.start = 1'b0;
    end while (!(bus.done || bus.err) && edges < 3000);
    if (!(bus.done || bus.err)) check("run_timeout", 32'd0, 32'd1);
  endtask

  // Run one GCD and compare against hand-derived outcome; n = subtractions to convergence.
  task automatic check_run(input string name, input logic [15:0] a, input logic [15:0] b,
                           input bit exp_zero_err, input int n, input int g, input bit hold);
    int edges, loads, held;
    run_gcd(a, b, hold, edges, loads);
    if (exp_zero_err) begin
      check({name, "_err"},   {bus.done, bus.err}, 2'b01);
      check({name, "_iter"},  bus.iter_cnt, 0);
      check({name, "_edges"}, edges, 4);
    end else if (n > LIM) begin
      check({name, "_lim_err"}, {bus.done, bus.err}, 2'b01);
      check({name, "_iter"},    bus.iter_cnt, LIM);
      check({name, "_edges"},   edges, 4 + 2 * LIM);
    end else begin
      check({name, "_done"},  {bus.done, bus.err}, 2'b10);
      check({name, "_iter"},  bus.iter_cnt, n);
      check({name, "_edges"}, edges, 4 + 2 * n);
      check({name, "_loads"}, loads, 2 + n);
      check({name, "_gcd"},   a_reg, g);
    end
    check({name, "_busy"}, bus.busy, 1'b0);
    held = int'(bus.iter_cnt);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check({name, "_idle"}, outs(), 8'd0);
    check({name, "_hold"}, bus.iter_cnt, held);
    $display("[TB] %s A=%0d B=%0d iter=%0d", name, a, b, held);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    bit          zero_err;
    int          n;
    int          g;
  } vec_t;

  vec_t vecs[10];

  initial begin
    vecs[0] = '{16'd48,  16'd18, 1'b0, 4,   6};
    vecs[1] = '{16'd7,   16'd7,  1'b0, 0,   7};
    vecs[2] = '{16'd0,   16'd5,  1'b1, 0,   0};
    vecs[3] = '{16'd5,   16'd0,  1'b1, 0,   0};
    vecs[4] = '{16'd0,   16'd0,  1'b1, 0,   0};
    vecs[5] = '{16'd21,  16'd6,  1'b0, 4,   3};
    vecs[6] = '{16'd1,   16'd10, 1'b0, 9,   1};
    vecs[7] = '{16'd100, 16'd75, 1'b0, 3,   25};
    vecs[8] = '{16'd13,  16'd8,  1'b0, 5,   1};
    vecs[9] = '{16'd255, 16'd1,  1'b0, 254, 1};

    bus.start = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", outs(), 8'd0);
    check("reset_iter", bus.iter_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_no_start", outs(), 8'd0);

    for (int i = 0; i < 10; i++) begin
      check_run($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].zero_err,
                vecs[i].n, vecs[i].g, 1'b1);
    end

    // Start dropped right after being sampled: run still completes.
    check_run("start_drop", 16'd21, 16'd6, 1'b0, 4, 3, 1'b0);

    // Async reset in the middle of a SUB_A cycle.
    begin
      int guard = 0;
      @(negedge clk);
      op_a = 16'd48;
      op_b = 16'd18;
      bus.start = 1'b1;
      do begin
        @(posedge clk);
        #1;
        guard++;
      end while (!(bus.ldA && !bus.sel_in) && guard < 50);
      check("rst_reached_sub_a", {bus.ldA, bus.sel_in, bus.sel2}, 3'b101);
      #2;
      rst = 1'b1;
      #1;
      check("rst_mid_outs", outs(), 8'd0);
      check("rst_mid_iter", bus.iter_cnt, 0);
      @(negedge clk);
      bus.start = 1'b0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_then_idle", outs(), 8'd0);
      check_run("after_rst", 16'd48, 16'd18, 1'b0, 4, 6, 1'b1);
    end

    // Held start parks in DONE; a low cycle is required before the next LOAD_A.
    begin
      int edges, loads, guard;
      run_gcd(16'd7, 16'd7, 1'b1, edges, loads);
      check("hold_first_done", {bus.done, bus.err}, 2'b10);
      for (int k = 0; k < 10; k++) begin
        @(posedge clk);
        #1;
        check($sformatf("hold_done_c%0d", k), outs(), 8'b0000_0010);
      end
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("hold_idle", outs(), 8'd0);
      @(negedge clk);
      op_a = 16'd9;
      op_b = 16'd9;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      check("hold_reload", outs(), 8'b1010_0100);
      guard = 0;
      while (!bus.done && guard < 50) begin
        @(posedge clk);
        #1;
        guard++;
      end
      check("hold_second_done", {bus.done, a_reg}, {1'b1, 16'd9});
      @(negedge clk);
      bus.start = 1'b0;
      @(posedge clk);
      #1;
      check("hold_final_idle", outs(), 8'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
